fc_layer_sequencer: RTL and testbench
=====================================

// Module: fc_layer_sequencer
// PURPOSE
//   Sequences one fully-connected layer inference around the fc_in datapath.
//   - On start, streams INPUT_SIZE activations and weight rows from on-chip
//     memories into the FC MAC array.
//   - Waits for the array's result and captures all NUM_NEURONS outputs.
//   - Drains the outputs one neuron per beat over a valid/ready stream to the
//     next layer.
// PARAMETERS
//   NUM_NEURONS  8   neurons in the FC array; number of output beats
//   INPUT_SIZE   16  activations per inference; must be >= 2
//   ACC_WIDTH    32  width of one FC result word
//   ADDR_WIDTH   $clog2(INPUT_SIZE)  activation/weight address width (derived)
//   IDX_WIDTH    $clog2(NUM_NEURONS) output neuron index width (derived)
// PORTS
//   clk          in   1                      clock
//   rst_n        in   1                      synchronous, active-low reset
//   start        in   1                      request one inference; accepted only in IDLE
//   busy         out  1                      high whenever state != IDLE
//   done         out  1                      1-cycle pulse after the last output beat
//   seq_err      out  1                      sticky: fc_out_valid seen outside WAIT_FC; cleared on accepted start
//   mem_rd_en    out  1                      read strobe, activation buffer and weight ROM
//   mem_rd_addr  out  ADDR_WIDTH             input index k (activation k, weight row k)
//   fc_in_valid  out  1                      drives the FC array in_valid; mem data has 1-cycle read latency
//   fc_out_valid in   1                      FC array out_valid pulse
//   fc_out       in   NUM_NEURONS*ACC_WIDTH  FC results, flattened, neuron 0 in LSBs
//   res_valid    out  1                      output stream valid
//   res_ready    in   1                      output stream ready
//   res_data     out  ACC_WIDTH              result of neuron res_idx
//   res_idx      out  IDX_WIDTH              neuron index of the current beat
//   res_last     out  1                      high on beat NUM_NEURONS-1
// BEHAVIOUR
//   Reset values:
//   - All outputs are 0; state IDLE; counters and result buffer are 0.
//   - Reset mid-operation aborts immediately; no done pulse.
//   - The FC array shares rst_n, so its accumulators clear together with this block.
//   FSM states and transitions:
//   - IDLE -> FEED when start=1.
//   - FEED: registered mem_rd_en=1 for exactly INPUT_SIZE consecutive cycles;
//     mem_rd_addr = 0..INPUT_SIZE-1. After the last read -> WAIT_FC.
//   - fc_in_valid = mem_rd_en delayed 1 cycle; it is never gapped within an inference.
//   - WAIT_FC: when fc_out_valid=1, arm capture. Next cycle, latch all fc_out
//     words into the result buffer (fc_out updates 1 cycle after out_valid),
//     then -> DRAIN.
//   - DRAIN: res_valid=1; res_data/res_idx come from the buffer at index idx.
//     - On res_valid&&res_ready: idx+1.
//     - On the handshake of beat NUM_NEURONS-1: done=1 for the following cycle,
//       state -> IDLE.
//   Cycle timeline (start sampled at edge of cycle 0):
//   - mem_rd_en: cycles 1..N
//   - fc_in_valid: cycles 2..N+1
//   - fc_out_valid: cycle N+2
//   - capture: cycle N+3
//   - res_valid first high: cycle N+4
//   Handshake rules:
//   - res_data, res_idx and res_last hold stable while res_valid && !res_ready.
//   - res_valid never drops before its handshake.
//   - Back-to-back beats are allowed: 1 beat per cycle with res_ready held high.
//   Boundary conditions:
//   - start while busy is ignored, including in the done cycle.
//   - start in the cycle after done is accepted.
//   - fc_out_valid in IDLE, FEED or DRAIN sets seq_err and is otherwise ignored.
//   - A second fc_out_valid in WAIT_FC while capture is armed is ignored.
//   - The idx counter wraps to 0 on the final beat.
//   - Counters are sized so INPUT_SIZE-1 and NUM_NEURONS-1 are representable;
//     there is no overflow.
// TESTING
//   1. Reset, then start=1 for 1 cycle, N=16, res_ready=1:
//      - mem_rd_addr 0..15 on cycles 1..16; fc_in_valid on cycles 2..17.
//      - Model fc_out_valid at 18; res beats idx 0..7 on cycles 20..27.
//      - res_last on beat 7; done at 28.
//   2. Random res_ready backpressure (stall 3 cycles on beat 2):
//      - res_data/res_idx stay stable during the stall.
//      - All 8 words match the captured values (fc_out word i = 1000+i).
//   3. start pulsed during FEED and in the done cycle: no restart, one inference only.
//      start on the cycle after done: new FEED begins at the next cycle.
//   4. fc_out_valid injected in IDLE: seq_err=1, no state change.
//      A later accepted start clears seq_err.
//   5. rst_n=0 at cycle 8 of FEED:
//      - Next cycle all outputs are 0 and state is IDLE; no done pulse.
//      - A subsequent start runs a full, correct inference.

Source files
------------

// File: rtl/fc_layer_sequencer_if.sv
// fc_layer_sequencer_if: memory read, FC array and result stream signals of the sequencer
interface fc_layer_sequencer_if #(
  parameter int NUM_NEURONS = 8,
  parameter int INPUT_SIZE  = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int ADDR_WIDTH  = $clog2(INPUT_SIZE),
  parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
);
  logic                             mem_rd_en;
  logic [ADDR_WIDTH-1:0]            mem_rd_addr;
  logic                             fc_in_valid;
  logic                             fc_out_valid;
  logic [NUM_NEURONS*ACC_WIDTH-1:0] fc_out;
  logic                             res_valid;
  logic                             res_ready;
  logic [ACC_WIDTH-1:0]             res_data;
  logic [IDX_WIDTH-1:0]             res_idx;
  logic                             res_last;
  modport master (
    output mem_rd_en, mem_rd_addr, fc_in_valid, res_valid, res_data, res_idx, res_last,
    input  fc_out_valid, fc_out, res_ready
  );
  modport slave (
    input  mem_rd_en, mem_rd_addr, fc_in_valid, res_valid, res_data, res_idx, res_last,
    output fc_out_valid, fc_out, res_ready
  );
endinterface

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: feeds one FC layer inference, captures the array result and drains it per neuron
module fc_layer_sequencer #(
  parameter int NUM_NEURONS = 8,
  parameter int INPUT_SIZE  = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int ADDR_WIDTH  = $clog2(INPUT_SIZE),
  parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic seq_err,
  fc_layer_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, FEED, WAIT_FC, DRAIN} state_t;
  state_t state, state_n;
  logic armed;
  logic [IDX_WIDTH-1:0] idx;
  logic [ACC_WIDTH-1:0] res_buf [NUM_NEURONS];
  logic accept, last_rd, beat, last_beat;
  // the done cycle is already IDLE, so start is masked by done there
  assign accept    = state == IDLE && start && !done;
  assign last_rd   = state == FEED && bus.mem_rd_addr == ADDR_WIDTH'(INPUT_SIZE - 1);
  assign beat      = state == DRAIN && bus.res_ready;
  assign last_beat = beat && idx == IDX_WIDTH'(NUM_NEURONS - 1);
  assign busy          = state != IDLE;
  assign bus.res_valid = state == DRAIN;
  assign bus.res_data  = res_buf[idx];
  assign bus.res_idx   = idx;
  assign bus.res_last  = state == DRAIN && idx == IDX_WIDTH'(NUM_NEURONS - 1);
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_n;
  always_comb begin
    state_n = accept                   ? FEED    :
              last_rd                  ? WAIT_FC :
              (state == WAIT_FC && armed) ? DRAIN :
              last_beat                ? IDLE    : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.mem_rd_en   <= 1'b0;
      bus.mem_rd_addr <= '0;
      bus.fc_in_valid <= 1'b0;
      armed           <= 1'b0;
      idx             <= '0;
      done            <= 1'b0;
      seq_err         <= 1'b0;
      res_buf         <= '{default: '0};
    end else begin
      bus.mem_rd_en   <= accept || (bus.mem_rd_en && !last_rd);
      bus.mem_rd_addr <= (state == FEED && !last_rd) ? bus.mem_rd_addr + 1'b1 : '0;
      bus.fc_in_valid <= bus.mem_rd_en;
      armed           <= state == WAIT_FC && !armed && bus.fc_out_valid;
      idx             <= last_beat ? '0 : beat ? idx + 1'b1 : idx;
      done            <= last_beat;
      seq_err         <= (bus.fc_out_valid && state != WAIT_FC) || (seq_err && !accept);
      // fc_out is valid the cycle after the array's out_valid pulse
      if (armed) for (int i = 0; i < NUM_NEURONS; i++) res_buf[i] <= bus.fc_out[i*ACC_WIDTH +: ACC_WIDTH];
    end
  end
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb_fc_layer_sequencer: directed inferences checked every cycle against a timeline model of the layer
module tb_fc_layer_sequencer;
  localparam int NN = 8, IN = 16, AW = 32;
  localparam int JUNK = 32'h5A5A0000;
  logic clk = 0, rst_n = 0, start = 0;
  logic busy, done, seq_err;
  logic fc_ov_model = 0, fc_ov_inj = 0;
  fc_layer_sequencer_if #(.NUM_NEURONS(NN), .INPUT_SIZE(IN), .ACC_WIDTH(AW)) bus ();
  fc_layer_sequencer #(.NUM_NEURONS(NN), .INPUT_SIZE(IN), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .seq_err(seq_err), .bus(bus)
  );
  assign bus.fc_out_valid = fc_ov_model | fc_ov_inj;
  always #5 clk = ~clk;

  int cyc = 0, checks = 0, fails = 0;
  int t0 = -1, beats = 0, done_cyc = -100, k = 0;
  int s1 = -100, inj_c = -100, fc_base = 0, fc_cnt = 0;
  bit m_err = 0, armed_chk = 0, e_rv = 0, on = 0, err_set = 0, fin = 0, timed_out = 0, fc_pend = 0;

  function automatic logic [NN*AW-1:0] words(int base);
    logic [NN*AW-1:0] w;
    for (int i = 0; i < NN; i++) w[i*AW +: AW] = AW'(base + i);
    return w;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // FC array stand-in: out_valid one cycle after the last in_valid, results the cycle after that
  always @(negedge clk) begin
    fc_ov_model = fc_cnt == IN && !bus.fc_in_valid;
    bus.fc_out  = fc_pend ? words(fc_base) : words(JUNK);
    fc_pend     = fc_ov_model;
    fc_cnt      = bus.fc_in_valid ? fc_cnt + 1 : 0;
  end

  // model: an inference accepted at cycle t0 owns a fixed timeline; drain advances one beat per handshake
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      t0 = -1; beats = 0; m_err = 0; done_cyc = -100; armed_chk = 1;
    end else begin
      err_set = bus.fc_out_valid && !(t0 >= 0 && k >= IN + 1 && k <= IN + 3);
      if (start && t0 < 0 && cyc != done_cyc) begin
        t0 = cyc; beats = 0; m_err = err_set;
      end else m_err = m_err | err_set;
      if (e_rv && bus.res_ready) begin
        beats++;
        if (beats == NN) begin done_cyc = cyc + 1; t0 = -1; end
      end
    end
    cyc++;
    #1;
    on   = t0 >= 0;
    k    = cyc - t0;
    e_rv = on && k >= IN + 4;
    if (armed_chk) begin
      chk("mem_rd_en", bus.mem_rd_en, on && k >= 1 && k <= IN);
      chk("mem_rd_addr", bus.mem_rd_addr, (on && k >= 1 && k <= IN) ? k - 1 : 0);
      chk("fc_in_valid", bus.fc_in_valid, on && k >= 2 && k <= IN + 1);
      chk("busy", busy, on && k >= 1);
      chk("res_valid", bus.res_valid, e_rv);
      chk("res_idx", bus.res_idx, e_rv ? beats : 0);
      chk("res_last", bus.res_last, e_rv && beats == NN - 1);
      if (e_rv) chk("res_data", bus.res_data, fc_base + beats);
      chk("done", done, cyc == done_cyc);
      chk("seq_err", seq_err, m_err);
      if (cyc == s1 + 16) begin chk("t1_addr15", bus.mem_rd_addr, 15); chk("t1_rd16", bus.mem_rd_en, 1); end
      if (cyc == s1 + 17) begin chk("t1_rd_off", bus.mem_rd_en, 0); chk("t1_fiv17", bus.fc_in_valid, 1); end
      if (cyc == s1 + 19) chk("t1_rv19", bus.res_valid, 0);
      if (cyc == s1 + 20) begin
        chk("t1_rv20", bus.res_valid, 1); chk("t1_idx0", bus.res_idx, 0); chk("t1_data0", bus.res_data, 5000);
      end
      if (cyc == s1 + 27) begin
        chk("t1_last", bus.res_last, 1); chk("t1_idx7", bus.res_idx, 7); chk("t1_data7", bus.res_data, 5007);
      end
      if (cyc == s1 + 28) begin chk("t1_done28", done, 1); chk("t1_rv28", bus.res_valid, 0); end
      if (cyc == inj_c + 1) begin chk("t4_err", seq_err, 1); chk("t4_idle", busy, 0); end
    end
    if (fin) begin
      chk("timeout", timed_out, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
    end
  end

  initial begin
    bit got_done;
    int stall, s5;
    bus.res_ready = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    // single inference, ready held high
    @(negedge clk);
    fc_base = 5000; bus.res_ready = 1; start = 1; s1 = cyc;
    @(negedge clk); start = 0;
    while (cyc < s1 + 32) @(negedge clk);
    // backpressure, start ignored in FEED and in the done cycle, accepted right after
    fc_base = 1000; start = 1;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    start = 1;
    @(negedge clk); start = 0;
    got_done = 0; stall = 0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      @(negedge clk);
      if (done) begin got_done = 1; start = 1; end
      else if (bus.res_valid && bus.res_idx == 2 && stall < 3) begin bus.res_ready = 0; stall++; end
      else bus.res_ready = $urandom_range(0, 2) != 0;
    end
    if (!got_done) timed_out = 1;
    fc_base = 7000;
    @(negedge clk); bus.res_ready = 1;
    @(negedge clk); start = 0;
    repeat (30) @(negedge clk);
    // stray out_valid in IDLE, then a start that clears it
    fc_ov_inj = 1; inj_c = cyc;
    @(negedge clk); fc_ov_inj = 0;
    repeat (3) @(negedge clk);
    fc_base = 9000; start = 1; s5 = cyc;
    @(negedge clk); start = 0;
    while (cyc < s5 + 8) @(negedge clk);
    rst_n = 0;
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);
    start = 1;
    @(negedge clk); start = 0;
    repeat (32) @(negedge clk);
    fin = 1;
  end

  initial begin
    #20000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end
endmodule
